qnet_dbg_trace: RTL and testbench
=================================

Name: qnet_dbg_trace

Overview:
- Trace capture buffer downstream of the QNET command-state debug stage.
- Input is the 32-bit packed state-history word {LT, LT_r, LT_r2, LT_r3, LT_r4}, 6 bits each, newest in bits [31:26].
- Records every change of that word with a delta timestamp into a circular RAM.
- Optional freeze on a chosen state code, with a post-trigger window; software reads entries back oldest-first.

Parameters:
- AW, 5, buffer address width; DEPTH = 2**AW entries.
- TS_W, 16, delta-timestamp width (cycles since previous capture).
- POST_TRIG, 8, captures recorded after the trigger entry before freezing (0..DEPTH-1).

Ports:
- st_clk_i  in  1  clock.
- st_rst_ni  in  1  reset, asynchronous, active-low.
- debug_dt_i  in  32  packed state-history word from the command debug stage.
- arm_i  in  1  pulse: clear buffer, start capture.
- stop_i  in  1  pulse: force freeze.
- trig_en_i  in  1  enable trigger on code match.
- trig_code_i  in  6  state code to trigger on (e.g. 63 = ST_ERROR).
- rd_en_i  in  1  read request.
- rd_addr_i  in  AW  entry index relative to oldest (0 = oldest).
- rd_dt_o  out  32  read data word.
- rd_ts_o  out  TS_W  read delta timestamp.
- rd_vld_o  out  1  read data valid.
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- count_o  out  AW+1  valid entries, saturates at DEPTH.
- trig_o  out  1  trigger seen since last arm (sticky).

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; wr_ptr, count_o, wrapped, ts_cnt, post_cnt, prev_r all 0.
  - trig_o=0, rd_vld_o=0, rd_dt_o=0, rd_ts_o=0.
  - RAM contents undefined.
- Reset asserted mid-capture aborts immediately; no partial-entry guarantees.
- prev_r registers debug_dt_i every cycle.
- Capture event (ARMED or POST only): debug_dt_i != prev_r. Writes {debug_dt_i, ts_cnt} at wr_ptr, then:
  - wr_ptr increments mod DEPTH.
  - count_o increments, saturating at DEPTH.
  - wrapped sets when wr_ptr wraps.
- ts_cnt:
  - Increments every cycle, saturating at 2**TS_W-1.
  - Cleared to 1 on the cycle after a capture, i.e. the stored value is cycles since the previous capture.
  - Cleared to 0 on arm.
- arm_i (any state, highest priority):
  - wr_ptr=0, count=0, wrapped=0, trig_o=0, ts_cnt=0.
  - Writes baseline entry {debug_dt_i, 0} at index 0 (count becomes 1, wr_ptr 1).
  - Goes to ARMED.
  - A change on the arm cycle is not captured again.
- FSM transitions:
  - IDLE: waits for arm_i.
  - ARMED, capture with trig_en_i=1 and debug_dt_i[31:26]==trig_code_i: trig_o=1, post_cnt=POST_TRIG; go to POST, or to DONE if POST_TRIG=0. Trigger entry is written.
  - ARMED with trig_en_i=0: captures indefinitely, overwriting oldest.
  - POST: each capture decrements post_cnt; the capture that takes it to 0 is written, then DONE. Further code matches are ignored.
  - DONE: no writes; buffer frozen until arm_i.
  - stop_i in ARMED/POST goes to DONE next cycle. A capture on that same cycle is still written.
  - stop_i in IDLE/DONE has no effect.
  - arm_i and stop_i together: arm wins.
- Read path:
  - Physical address = (wrapped ? wr_ptr : 0) + rd_addr_i, mod DEPTH, using wr_ptr as sampled on the rd_en_i cycle.
  - rd_vld_o pulses 1 cycle after rd_en_i; rd_dt_o/rd_ts_o are valid that cycle and hold until the next read.
  - rd_addr_i >= count_o: rd_vld_o still pulses, data = 0.
  - Reads allowed in any state. Read and write in the same cycle to the same address return old data (read-first).
- RAM is inferable as simple dual-port (1 write, 1 read), 32+TS_W bits wide.

Test Plan:
- Baseline/changes: arm with debug_dt_i=0x0; change to 0x04000000 after 10 cycles, then 0x08100000 after 3 more -> count_o=3; entries {0x0,0}, {0x04000000,10}, {0x08100000,3}.
- Trigger window: POST_TRIG=2, trig_en=1, code 63; drive words with newest codes 5,63,6,7,8 -> trig_o=1, state DONE after code 7, count_o=4 (baseline+5,63,6,7), code 8 not stored.
- Wrap: AW=5, trig_en=0; 40 distinct changes after arm -> count_o=32, wrapped; rd_addr 0 returns the 9th change, rd_addr 31 returns the 40th.
- Timestamp saturation: TS_W=16, no change for 70000 cycles then one change -> stored ts = 0xFFFF.
- Priority: arm_i and stop_i in the same cycle while DONE -> state ARMED, count_o=1, trig_o=0; stop_i alone next cycle -> DONE with count_o=1.
- Async reset mid-POST: assert st_rst_ni low between clock edges -> state_o=0, count_o=0, trig_o=0, rd_vld_o=0 immediately, before the next edge.

Source files
------------

// File: rtl/qnet_dbg_trace.sv
// Trace buffer: records each change of the 32-bit state-history word with a delta timestamp in a circular RAM.
// Latency: a capture is written on the cycle the change is seen; a read returns data one cycle after rd_en_i.
// Backpressure: none; the buffer overwrites the oldest entry while ARMED and stops writing once DONE.
module qnet_dbg_trace #(
   parameter int AW        = 5,
   parameter int TS_W      = 16,
   parameter int POST_TRIG = 8
) (
   input  logic            st_clk_i,
   input  logic            st_rst_ni,
   input  logic [31:0]     debug_dt_i,
   input  logic            arm_i,
   input  logic            stop_i,
   input  logic            trig_en_i,
   input  logic [5:0]      trig_code_i,
   input  logic            rd_en_i,
   input  logic [AW-1:0]   rd_addr_i,
   output logic [31:0]     rd_dt_o,
   output logic [TS_W-1:0] rd_ts_o,
   output logic            rd_vld_o,
   output logic [1:0]      state_o,
   output logic [AW:0]     count_o,
   output logic            trig_o
);

   localparam int CW    = AW + 1;
   localparam int DEPTH = 2 ** AW;
   localparam int EW    = 32 + TS_W;
   localparam logic [TS_W-1:0] TS_MAX    = '1;
   localparam logic [CW-1:0]   COUNT_MAX = CW'(DEPTH);
   localparam logic [AW-1:0]   POST_INIT = AW'(POST_TRIG);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            wrapped_q, wrapped_d;
   logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
   logic [AW-1:0]   post_cnt_q, post_cnt_d;
   logic [31:0]     prev_q, prev_d;
   logic            trig_q, trig_d;
   logic            rd_vld_q, rd_vld_d;
   logic            rd_zero_q, rd_zero_d;

   logic            capture;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [EW-1:0]   wdata;
   logic [AW-1:0]   rd_phys;
   logic            rd_oob;

   logic [EW-1:0]   mem [DEPTH];
   logic [EW-1:0]   rd_ram_q;

   // Capture control, pointer/count bookkeeping and trigger FSM; arm overrides everything else.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      wrapped_d  = wrapped_q;
      ts_cnt_d   = (ts_cnt_q == TS_MAX) ? ts_cnt_q : ts_cnt_q + TS_W'(1);
      post_cnt_d = post_cnt_q;
      trig_d     = trig_q;
      prev_d     = debug_dt_i;
      capture    = 1'b0;
      we         = 1'b0;
      waddr      = wr_ptr_q;
      wdata      = {debug_dt_i, ts_cnt_q};

      if (arm_i) begin
         // Baseline entry at index 0; prev_q picks up the same word so it is not captured twice.
         we         = 1'b1;
         waddr      = '0;
         wdata      = {debug_dt_i, {TS_W{1'b0}}};
         wr_ptr_d   = AW'(1);
         count_d    = CW'(1);
         wrapped_d  = 1'b0;
         trig_d     = 1'b0;
         ts_cnt_d   = '0;
         post_cnt_d = '0;
         state_d    = ST_ARMED;
      end else begin
         capture = ((state_q == ST_ARMED) || (state_q == ST_POST)) && (debug_dt_i != prev_q);
         if (capture) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            ts_cnt_d = TS_W'(1);
            if (count_q != COUNT_MAX) count_d = count_q + CW'(1);
            if (wr_ptr_q == '1) wrapped_d = 1'b1;
         end
         case (state_q)
            ST_ARMED: begin
               if (capture && trig_en_i && (debug_dt_i[31:26] == trig_code_i)) begin
                  trig_d     = 1'b1;
                  post_cnt_d = POST_INIT;
                  state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               if (capture) begin
                  post_cnt_d = post_cnt_q - AW'(1);
                  if (post_cnt_q == AW'(1)) state_d = ST_DONE;
               end
            end
            default: ;
         endcase
         // A forced stop still lets this cycle's capture land.
         if (stop_i && ((state_q == ST_ARMED) || (state_q == ST_POST))) state_d = ST_DONE;
      end
   end

   // Read address is relative to the oldest entry; entries past count_o read back as zero.
   always_comb begin
      rd_phys   = (wrapped_q ? wr_ptr_q : '0) + rd_addr_i;
      rd_oob    = ({1'b0, rd_addr_i} >= count_q);
      rd_vld_d  = rd_en_i;
      rd_zero_d = rd_en_i ? rd_oob : rd_zero_q;
   end

   // Control and read-status registers.
   always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
      if (!st_rst_ni) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         wrapped_q  <= 1'b0;
         ts_cnt_q   <= '0;
         post_cnt_q <= '0;
         prev_q     <= '0;
         trig_q     <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_zero_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         wrapped_q  <= wrapped_d;
         ts_cnt_q   <= ts_cnt_d;
         post_cnt_q <= post_cnt_d;
         prev_q     <= prev_d;
         trig_q     <= trig_d;
         rd_vld_q   <= rd_vld_d;
         rd_zero_q  <= rd_zero_d;
      end
   end

   // Simple dual-port RAM, read-first; read word held until the next read.
   always_ff @(posedge st_clk_i) begin
      if (we) mem[waddr] <= wdata;
      if (rd_en_i) rd_ram_q <= mem[rd_phys];
   end

   assign rd_dt_o  = rd_zero_q ? 32'd0 : rd_ram_q[EW-1:TS_W];
   assign rd_ts_o  = rd_zero_q ? '0 : rd_ram_q[TS_W-1:0];
   assign rd_vld_o = rd_vld_q;
   assign state_o  = state_q;
   assign count_o  = count_q;
   assign trig_o   = trig_q;

endmodule

// File: tb/tb_qnet_dbg_trace.sv
// Directed bench for qnet_dbg_trace: baseline/changes, trigger window, wrap, timestamp saturation,
// arm/stop priority and asynchronous reset.
module tb_qnet_dbg_trace;

   logic        clk;
   logic        rst_n;
   logic [31:0] debug_dt;
   logic        arm, stop, trig_en, rd_en;
   logic [5:0]  trig_code;
   logic [4:0]  rd_addr;
   logic [31:0] rd_dt;
   logic [15:0] rd_ts;
   logic        rd_vld;
   logic [1:0]  state;
   logic [5:0]  count;
   logic        trig;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rdt;
   logic [15:0] rts;
   logic        rv;

   qnet_dbg_trace #(.AW(5), .TS_W(16), .POST_TRIG(2)) dut (
      .st_clk_i    (clk),
      .st_rst_ni   (rst_n),
      .debug_dt_i  (debug_dt),
      .arm_i       (arm),
      .stop_i      (stop),
      .trig_en_i   (trig_en),
      .trig_code_i (trig_code),
      .rd_en_i     (rd_en),
      .rd_addr_i   (rd_addr),
      .rd_dt_o     (rd_dt),
      .rd_ts_o     (rd_ts),
      .rd_vld_o    (rd_vld),
      .state_o     (state),
      .count_o     (count),
      .trig_o      (trig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [4:0] a, output logic [31:0] dt, output logic [15:0] ts,
                          output logic vld);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      dt    = rd_dt;
      ts    = rd_ts;
      vld   = rd_vld;
      rd_en = 1'b0;
   endtask

   task automatic do_arm(input logic [31:0] w);
      debug_dt = w;
      arm      = 1'b1;
      tick();
      arm      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; debug_dt = '0; arm = 0; stop = 0; trig_en = 0; trig_code = '0; rd_en = 0; rd_addr = '0;
      repeat (3) tick();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
      checks++; if (count !== 6'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
      checks++; if (trig !== 1'b0) begin failures++; $display("FAIL rst_trig got=%0d exp=0", trig); end
      checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL rst_rd_vld got=%0d exp=0", rd_vld); end
      checks++; if (rd_dt !== 32'd0 || rd_ts !== 16'd0) begin
         failures++; $display("FAIL rst_rd_data got=%h/%h exp=0/0", rd_dt, rd_ts); end
      rst_n = 1'b1;
      repeat (2) tick();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", state); end
   endtask

   task automatic test_baseline();
      do_arm(32'h0000_0000);
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL base_state got=%0d exp=1", state); end
      checks++; if (count !== 6'd1) begin failures++; $display("FAIL base_count1 got=%0d exp=1", count); end
      repeat (10) tick();
      debug_dt = 32'h0400_0000;
      tick();
      repeat (2) tick();
      debug_dt = 32'h0810_0000;
      tick();
      checks++; if (count !== 6'd3) begin failures++; $display("FAIL base_count3 got=%0d exp=3", count); end
      do_read(5'd0, rdt, rts, rv);
      checks++; if (rv !== 1'b1 || rdt !== 32'h0 || rts !== 16'd0) begin
         failures++; $display("FAIL base_e0 got=%0d/%h/%0d exp=1/00000000/0", rv, rdt, rts); end
      tick();
      checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL rd_vld_pulse got=%0d exp=0", rd_vld); end
      checks++; if (rd_dt !== 32'h0) begin failures++; $display("FAIL rd_hold got=%h exp=00000000", rd_dt); end
      do_read(5'd1, rdt, rts, rv);
      checks++; if (rdt !== 32'h0400_0000 || rts !== 16'd10) begin
         failures++; $display("FAIL base_e1 got=%h/%0d exp=04000000/10", rdt, rts); end
      do_read(5'd2, rdt, rts, rv);
      checks++; if (rdt !== 32'h0810_0000 || rts !== 16'd3) begin
         failures++; $display("FAIL base_e2 got=%h/%0d exp=08100000/3", rdt, rts); end
      do_read(5'd5, rdt, rts, rv);
      checks++; if (rv !== 1'b1 || rdt !== 32'h0 || rts !== 16'd0) begin
         failures++; $display("FAIL base_oob got=%0d/%h/%0d exp=1/00000000/0", rv, rdt, rts); end
   endtask

   task automatic test_trigger();
      trig_en = 1'b1; trig_code = 6'd63;
      do_arm({6'd5, 26'h0});
      debug_dt = {6'd63, 6'd5, 20'h0};
      tick();
      checks++; if (trig !== 1'b1 || state !== 2'd2) begin
         failures++; $display("FAIL trig_hit got=%0d/%0d exp=1/2", trig, state); end
      debug_dt = {6'd6, 6'd63, 6'd5, 14'h0};
      tick();
      checks++; if (state !== 2'd2) begin failures++; $display("FAIL trig_post got=%0d exp=2", state); end
      debug_dt = {6'd7, 6'd6, 6'd63, 6'd5, 8'h0};
      tick();
      checks++; if (state !== 2'd3) begin failures++; $display("FAIL trig_done got=%0d exp=3", state); end
      debug_dt = {6'd8, 6'd7, 6'd6, 6'd63, 6'd5, 2'h0};
      tick();
      checks++; if (count !== 6'd4 || state !== 2'd3) begin
         failures++; $display("FAIL trig_frozen got=%0d/%0d exp=4/3", count, state); end
      do_read(5'd1, rdt, rts, rv);
      checks++; if (rdt !== {6'd63, 6'd5, 20'h0}) begin
         failures++; $display("FAIL trig_entry got=%h exp=%h", rdt, {6'd63, 6'd5, 20'h0}); end
      do_read(5'd3, rdt, rts, rv);
      checks++; if (rdt !== {6'd7, 6'd6, 6'd63, 6'd5, 8'h0} || rts !== 16'd1) begin
         failures++; $display("FAIL trig_last got=%h/%0d exp=%h/1", rdt, rts, {6'd7, 6'd6, 6'd63, 6'd5, 8'h0}); end
      trig_en = 1'b0;
   endtask

   task automatic test_priority();
      arm = 1'b1; stop = 1'b1;
      tick();
      arm = 1'b0; stop = 1'b0;
      checks++; if (state !== 2'd1 || count !== 6'd1 || trig !== 1'b0) begin
         failures++; $display("FAIL prio_arm got=%0d/%0d/%0d exp=1/1/0", state, count, trig); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (state !== 2'd3 || count !== 6'd1) begin
         failures++; $display("FAIL prio_stop got=%0d/%0d exp=3/1", state, count); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (state !== 2'd3) begin failures++; $display("FAIL stop_done got=%0d exp=3", state); end
      do_arm(32'h0000_0011);
      debug_dt = 32'h0000_0022; stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++; if (state !== 2'd3 || count !== 6'd2) begin
         failures++; $display("FAIL stop_capture got=%0d/%0d exp=3/2", state, count); end
   endtask

   task automatic test_wrap();
      do_arm(32'h0);
      for (int k = 1; k <= 40; k++) begin
         debug_dt = 32'(k);
         tick();
      end
      checks++; if (count !== 6'd32 || state !== 2'd1) begin
         failures++; $display("FAIL wrap_count got=%0d/%0d exp=32/1", count, state); end
      do_read(5'd0, rdt, rts, rv);
      checks++; if (rdt !== 32'd9 || rts !== 16'd1) begin
         failures++; $display("FAIL wrap_oldest got=%0d/%0d exp=9/1", rdt, rts); end
      do_read(5'd31, rdt, rts, rv);
      checks++; if (rdt !== 32'd40 || rts !== 16'd1) begin
         failures++; $display("FAIL wrap_newest got=%0d/%0d exp=40/1", rdt, rts); end
   endtask

   task automatic test_ts_sat();
      do_arm(32'h0000_0100);
      repeat (70000) tick();
      debug_dt = 32'h0000_0200;
      tick();
      checks++; if (count !== 6'd2) begin failures++; $display("FAIL sat_count got=%0d exp=2", count); end
      do_read(5'd1, rdt, rts, rv);
      checks++; if (rdt !== 32'h0000_0200 || rts !== 16'hFFFF) begin
         failures++; $display("FAIL sat_ts got=%h/%h exp=00000200/ffff", rdt, rts); end
   endtask

   task automatic test_async_reset();
      trig_en = 1'b1; trig_code = 6'd63;
      do_arm({6'd5, 26'h1});
      debug_dt = {6'd63, 26'h2};
      rd_en = 1'b1; rd_addr = 5'd0;
      tick();
      rd_en = 1'b0;
      checks++; if (state !== 2'd2 || rd_vld !== 1'b1) begin
         failures++; $display("FAIL ar_pre got=%0d/%0d exp=2/1", state, rd_vld); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (state !== 2'd0 || count !== 6'd0 || trig !== 1'b0 || rd_vld !== 1'b0) begin
         failures++; $display("FAIL ar_clear got=%0d/%0d/%0d/%0d exp=0/0/0/0", state, count, trig, rd_vld); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL ar_idle got=%0d exp=0", state); end
   endtask

   initial begin
      test_reset();
      test_baseline();
      test_trigger();
      test_priority();
      test_wrap();
      test_ts_sat();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
